// File: rtl/hb_taskq_pkg.sv
// Shared types, widths and the round-robin picker used by the banked task
// queue dispatcher and its per-bank FIFOs.
package hb_taskq_pkg;

  localparam int DATA_W_DFLT    = 32;
  localparam int NUM_REQ_DFLT   = 4;
  localparam int NUM_BANKS_DFLT = 2;
  localparam int REQ_IDX_W      = $clog2(NUM_REQ_DFLT);
  localparam int BANK_IDX_W     = $clog2(NUM_BANKS_DFLT);
  localparam int RR_MAX_N       = 32;

  typedef logic [DATA_W_DFLT-1:0] task_t;

  // First set bit of mask at or after ptr, wrapping modulo n; returns ptr when mask is empty.
  function automatic int rr_pick(input logic [RR_MAX_N-1:0] mask, input int ptr, input int n);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && mask[idx[4:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/hb_task_bank_fifo.sv
// Single task bank: DEPTH x DATA_W synchronous FIFO. Fullness and emptiness
// come from the registered count, so a full bank refuses a push even when popped.
module hb_task_bank_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage holds no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/hb_task_dispatcher.sv
// Task dispatcher: round-robin requester arbiter feeding a round-robin bank
// selector that skips full banks; each bank is an independent FIFO.
module hb_task_dispatcher
  import hb_taskq_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 4,
  parameter int DATA_W    = DATA_W_DFLT
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]             req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_BANKS-1:0]                  deq_valid,
  output logic [NUM_BANKS*DATA_W-1:0]           deq_data,
  input  logic [NUM_BANKS-1:0]                  deq_ready,
  output logic [NUM_BANKS*$clog2(DEPTH+1)-1:0]  bank_count,
  output logic [$clog2(NUM_REQ)-1:0]            last_grant_req,
  output logic [$clog2(NUM_BANKS)-1:0]          last_grant_bank,
  output logic [31:0]                           accept_cnt
);

  localparam int RW = $clog2(NUM_REQ);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = $clog2(DEPTH+1);

  logic [NUM_BANKS-1:0] bank_full;
  logic [NUM_BANKS-1:0] bank_empty;
  logic [NUM_BANKS-1:0] bank_push;
  logic [DATA_W-1:0]    push_data;

  logic [RW-1:0] grant_idx;
  logic [BW-1:0] bank_sel;
  logic          any_valid;
  logic          any_space;
  logic          accept;

  logic [RW-1:0] rr_req_q, rr_req_d;
  logic [BW-1:0] rr_bank_q, rr_bank_d;
  logic [RW-1:0] last_grant_req_q, last_grant_req_d;
  logic [BW-1:0] last_grant_bank_q, last_grant_bank_d;
  logic [31:0]   accept_cnt_q, accept_cnt_d;

  // Grant and bank choice are purely combinational off registered pointers and counts.
  always_comb begin
    any_valid = |req_valid;
    any_space = ~&bank_full;
    grant_idx = RW'(rr_pick(RR_MAX_N'(req_valid), int'(rr_req_q), NUM_REQ));
    bank_sel  = BW'(rr_pick(RR_MAX_N'(~bank_full), int'(rr_bank_q), NUM_BANKS));
    accept    = !reset && any_valid && any_space;
    push_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    req_ready = '0;
    bank_push = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
      bank_push[bank_sel]  = 1'b1;
    end
  end

  always_comb begin
    rr_req_d          = rr_req_q;
    rr_bank_d         = rr_bank_q;
    last_grant_req_d  = last_grant_req_q;
    last_grant_bank_d = last_grant_bank_q;
    accept_cnt_d      = accept_cnt_q;
    if (accept) begin
      rr_req_d          = (grant_idx == RW'(NUM_REQ-1)) ? '0 : grant_idx + RW'(1);
      rr_bank_d         = (bank_sel == BW'(NUM_BANKS-1)) ? '0 : bank_sel + BW'(1);
      last_grant_req_d  = grant_idx;
      last_grant_bank_d = bank_sel;
      accept_cnt_d      = accept_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_req_q          <= '0;
      rr_bank_q         <= '0;
      last_grant_req_q  <= '0;
      last_grant_bank_q <= '0;
      accept_cnt_q      <= '0;
    end else begin
      rr_req_q          <= rr_req_d;
      rr_bank_q         <= rr_bank_d;
      last_grant_req_q  <= last_grant_req_d;
      last_grant_bank_q <= last_grant_bank_d;
      accept_cnt_q      <= accept_cnt_d;
    end
  end

  assign last_grant_req  = last_grant_req_q;
  assign last_grant_bank = last_grant_bank_q;
  assign accept_cnt      = accept_cnt_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    hb_task_bank_fifo #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (bank_push[b]),
      .pop      (deq_ready[b]),
      .push_data(push_data),
      .head_data(deq_data[b*DATA_W +: DATA_W]),
      .count    (bank_count[b*CW +: CW]),
      .full     (bank_full[b]),
      .empty    (bank_empty[b])
    );
    assign deq_valid[b] = ~bank_empty[b];
  end

endmodule

// File: tb/tb_hb_task_dispatcher.sv
// Directed bench for hb_task_dispatcher (4 requesters, 2 banks, depth 4).
module tb_hb_task_dispatcher;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [1:0]   deq_valid;
  logic [63:0]  deq_data;
  logic [1:0]   deq_ready;
  logic [5:0]   bank_count;
  logic [1:0]   last_grant_req;
  logic [0:0]   last_grant_bank;
  logic [31:0]  accept_cnt;

  int checks = 0;
  int errors = 0;

  logic [2:0]  cnt0, cnt1;
  logic [31:0] dd0, dd1;
  assign cnt0 = bank_count[2:0];
  assign cnt1 = bank_count[5:3];
  assign dd0  = deq_data[31:0];
  assign dd1  = deq_data[63:32];

  hb_task_dispatcher #(
    .NUM_REQ  (4),
    .NUM_BANKS(2),
    .DEPTH    (4),
    .DATA_W   (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .deq_valid      (deq_valid),
    .deq_data       (deq_data),
    .deq_ready      (deq_ready),
    .bank_count     (bank_count),
    .last_grant_req (last_grant_req),
    .last_grant_bank(last_grant_bank),
    .accept_cnt     (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'hF;
    deq_ready = 2'b00;
    req_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tick();
    tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b exp %b", req_ready, 4'b0000); end
    checks++; if (accept_cnt !== 32'd0) begin errors++; $display("FAIL rst_accept_cnt got %0h exp 0", accept_cnt); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL rst_deq_valid got %b exp 00", deq_valid); end
    checks++; if (bank_count !== 6'd0) begin errors++; $display("FAIL rst_bank_count got %h exp 0", bank_count); end
    checks++; if (last_grant_req !== 2'd0 || last_grant_bank !== 1'b0) begin
      errors++; $display("FAIL rst_last_grant got %0d/%0d exp 0/0", last_grant_req, last_grant_bank);
    end
    reset = 1'b0;
  endtask

  task automatic test_rr_fill();
    logic [3:0] exp_ready [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] exp_req   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic       exp_bank  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== exp_ready[k]) begin errors++; $display("FAIL fill_req_ready[%0d] got %b exp %b", k, req_ready, exp_ready[k]); end
      tick();
      checks++; if (last_grant_req !== exp_req[k]) begin errors++; $display("FAIL fill_grant_req[%0d] got %0d exp %0d", k, last_grant_req, exp_req[k]); end
      checks++; if (last_grant_bank !== exp_bank[k]) begin errors++; $display("FAIL fill_grant_bank[%0d] got %0d exp %0d", k, last_grant_bank, exp_bank[k]); end
    end
    checks++; if (accept_cnt !== 32'd4) begin errors++; $display("FAIL fill_accept_cnt got %0d exp 4", accept_cnt); end
    checks++; if (cnt0 !== 3'd2 || cnt1 !== 3'd2) begin errors++; $display("FAIL fill_counts got %0d/%0d exp 2/2", cnt0, cnt1); end
    checks++; if (dd0 !== 32'hA0) begin errors++; $display("FAIL fill_head0 got %h exp a0", dd0); end
    checks++; if (dd1 !== 32'hA1) begin errors++; $display("FAIL fill_head1 got %h exp a1", dd1); end
    checks++; if (deq_valid !== 2'b11) begin errors++; $display("FAIL fill_deq_valid got %b exp 11", deq_valid); end
  endtask

  task automatic test_full_skip();
    for (int k = 0; k < 4; k++) tick();
    #1;
    checks++; if (cnt0 !== 3'd4 || cnt1 !== 3'd4) begin errors++; $display("FAIL full_counts got %0d/%0d exp 4/4", cnt0, cnt1); end
    checks++; if (accept_cnt !== 32'd8) begin errors++; $display("FAIL full_accept_cnt got %0d exp 8", accept_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_req_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (accept_cnt !== 32'd8) begin errors++; $display("FAIL full_hold_cnt got %0d exp 8", accept_cnt); end
    deq_ready = 2'b10;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_pop_ready got %b exp 0000", req_ready); end
    tick();
    deq_ready = 2'b00;
    checks++; if (cnt1 !== 3'd3) begin errors++; $display("FAIL full_pop_cnt1 got %0d exp 3", cnt1); end
    checks++; if (dd1 !== 32'hA3) begin errors++; $display("FAIL full_pop_head1 got %h exp a3", dd1); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_req_ready got %b exp 0001", req_ready); end
    tick();
    checks++; if (last_grant_bank !== 1'b1) begin errors++; $display("FAIL skip_bank got %0d exp 1", last_grant_bank); end
    checks++; if (cnt0 !== 3'd4 || cnt1 !== 3'd4) begin errors++; $display("FAIL skip_counts got %0d/%0d exp 4/4", cnt0, cnt1); end
    checks++; if (accept_cnt !== 32'd9) begin errors++; $display("FAIL skip_accept_cnt got %0d exp 9", accept_cnt); end
  endtask

  task automatic test_single_req();
    logic exp_bank [3] = '{1'b0, 1'b1, 1'b0};
    reset     = 1'b1;
    req_valid = 4'b0000;
    tick();
    reset     = 1'b0;
    deq_ready = 2'b11;
    tick();
    checks++; if (bank_count !== 6'd0 || deq_valid !== 2'b00) begin
      errors++; $display("FAIL pop_empty got cnt %h vld %b exp 0/00", bank_count, deq_valid);
    end
    deq_ready = 2'b00;
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      req_data[64 +: 32] = 32'hC0 + k;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready[%0d] got %b exp 0100", k, req_ready); end
      tick();
      checks++; if (last_grant_req !== 2'd2) begin errors++; $display("FAIL single_grant[%0d] got %0d exp 2", k, last_grant_req); end
      checks++; if (last_grant_bank !== exp_bank[k]) begin errors++; $display("FAIL single_bank[%0d] got %0d exp %0d", k, last_grant_bank, exp_bank[k]); end
      if (k == 0) begin
        checks++; if (deq_valid !== 2'b01) begin errors++; $display("FAIL single_latency got %b exp 01", deq_valid); end
      end
    end
    checks++; if (cnt0 !== 3'd2 || cnt1 !== 3'd1) begin errors++; $display("FAIL single_counts got %0d/%0d exp 2/1", cnt0, cnt1); end
    checks++; if (dd0 !== 32'hC0 || accept_cnt !== 32'd3) begin
      errors++; $display("FAIL single_head_cnt got %h/%0d exp c0/3", dd0, accept_cnt);
    end
  endtask

  task automatic test_push_pop();
    req_data[64 +: 32] = 32'hD0;
    tick();
    checks++; if (last_grant_bank !== 1'b1 || cnt1 !== 3'd2) begin
      errors++; $display("FAIL pp_setup got bank %0d cnt1 %0d exp 1/2", last_grant_bank, cnt1);
    end
    req_data[64 +: 32] = 32'hE0;
    deq_ready = 2'b01;
    #1;
    checks++; if (dd0 !== 32'hC0) begin errors++; $display("FAIL pp_head_before got %h exp c0", dd0); end
    tick();
    checks++; if (cnt0 !== 3'd2) begin errors++; $display("FAIL pp_count got %0d exp 2", cnt0); end
    checks++; if (dd0 !== 32'hC2) begin errors++; $display("FAIL pp_head_after got %h exp c2", dd0); end
    checks++; if (last_grant_bank !== 1'b0) begin errors++; $display("FAIL pp_bank got %0d exp 0", last_grant_bank); end
    req_valid = 4'b0000;
    tick();
    deq_ready = 2'b00;
    checks++; if (dd0 !== 32'hE0 || cnt0 !== 3'd1) begin
      errors++; $display("FAIL pp_tail got %h cnt %0d exp e0/1", dd0, cnt0);
    end
  endtask

  task automatic test_mid_reset();
    reset     = 1'b1;
    req_valid = 4'hF;
    deq_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mrst_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (deq_valid !== 2'b00 || bank_count !== 6'd0) begin
      errors++; $display("FAIL mrst_banks got vld %b cnt %h exp 00/0", deq_valid, bank_count);
    end
    checks++; if (accept_cnt !== 32'd0) begin errors++; $display("FAIL mrst_accept_cnt got %0d exp 0", accept_cnt); end
    checks++; if (dut.rr_req_q !== 2'd0 || last_grant_req !== 2'd0) begin
      errors++; $display("FAIL mrst_ptr got rr %0d last %0d exp 0/0", dut.rr_req_q, last_grant_req);
    end
    reset     = 1'b0;
    deq_ready = 2'b00;
    req_valid = 4'b1010;
    req_data  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mrst_first_ready got %b exp 0010", req_ready); end
    tick();
    checks++; if (last_grant_req !== 2'd1 || dd0 !== 32'hB1) begin
      errors++; $display("FAIL mrst_first_grant got %0d/%h exp 1/b1", last_grant_req, dd0);
    end
    checks++; if (accept_cnt !== 32'd1 || deq_valid !== 2'b01) begin
      errors++; $display("FAIL mrst_after got cnt %0d vld %b exp 1/01", accept_cnt, deq_valid);
    end
  endtask

  task automatic test_cnt_wrap();
    force dut.accept_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.accept_cnt_q;
    checks++; if (accept_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffffffff", accept_cnt); end
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready got %b exp 1000", req_ready); end
    tick();
    checks++; if (accept_cnt !== 32'd0) begin errors++; $display("FAIL wrap_accept_cnt got %h exp 0", accept_cnt); end
    checks++; if (last_grant_req !== 2'd3 || last_grant_bank !== 1'b1) begin
      errors++; $display("FAIL wrap_grant got %0d/%0d exp 3/1", last_grant_req, last_grant_bank);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    deq_ready = '0;
    test_reset();
    test_rr_fill();
    test_full_skip();
    test_single_req();
    test_push_pop();
    test_mid_reset();
    test_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
